// File: rtl/carbondma_pkg.sv
// Shared CarbonDMA types and constants: opcodes, channel status bits, and the
// scheduler FSM state and job payload used by the channel scheduler.
package carbondma_pkg;

    localparam logic CARBONDMA_OP_COPY = 1'b0;
    localparam logic CARBONDMA_OP_FILL = 1'b1;

    localparam int unsigned CARBONDMA_CH_STAT_BUSY = 0;
    localparam int unsigned CARBONDMA_CH_STAT_DONE = 1;
    localparam int unsigned CARBONDMA_CH_STAT_ERR  = 2;

    localparam int unsigned CARBONDMA_SCHED_CH_IDX_W = 3;
    localparam int unsigned CARBONDMA_JOB_ADDR_W     = 64;
    localparam int unsigned CARBONDMA_JOB_LEN_W      = 32;
    localparam int unsigned CARBONDMA_JOB_FILL_W     = 32;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_ISSUE = 2'd1,
        SCHED_WAIT  = 2'd2
    } sched_state_e;

    // Fields sized for the widest supported configuration.
    typedef struct packed {
        logic                            op;
        logic [CARBONDMA_JOB_ADDR_W-1:0] src;
        logic [CARBONDMA_JOB_ADDR_W-1:0] dst;
        logic [CARBONDMA_JOB_LEN_W-1:0]  len;
        logic [CARBONDMA_JOB_FILL_W-1:0] fill;
    } carbondma_job_t;

endpackage

// File: rtl/carbondma_rr_arb.sv
// Round-robin arbiter: first set request at or after ptr (wrapping) wins.
module carbondma_rr_arb #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int unsigned c;
    logic [N-1:0] req_sh;

    always_comb begin
        gnt    = '0;
        idx    = '0;
        any    = 1'b0;
        c      = 0;
        req_sh = '0;
        for (int unsigned i = 0; i < N; i++) begin
            c      = (32'(ptr) + i) % N;
            req_sh = req >> c;
            if (!any && req_sh[0]) begin
                any = 1'b1;
                gnt = N'(1) << c;
                idx = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/carbondma_ch_sched.sv
// CarbonDMA per-channel job scheduler: latches starts, arbitrates, issues one job
// at a time to the engine. Optional macro CARBONDMA_SCHED_PRIO_EN adds a high-priority class.
module carbondma_ch_sched
    import carbondma_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned LEN_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en_i,
    input  logic                       clr_err_i,
    input  logic [NUM_CH-1:0]          ch_start_i,
    input  logic [NUM_CH-1:0]          ch_fill_i,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_src_i,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_dst_i,
    input  logic [NUM_CH*LEN_W-1:0]    ch_len_i,
    input  logic [NUM_CH*32-1:0]       ch_fillval_i,
    input  logic [NUM_CH-1:0]          ch_prio_i,
    output logic                       eng_req_valid_o,
    input  logic                       eng_req_ready_i,
    output logic [2:0]                 eng_req_ch_o,
    output logic                       eng_req_op_o,
    output logic [ADDR_W-1:0]          eng_req_src_o,
    output logic [ADDR_W-1:0]          eng_req_dst_o,
    output logic [LEN_W-1:0]           eng_req_len_o,
    output logic [31:0]                eng_req_fill_o,
    input  logic                       eng_done_i,
    input  logic                       eng_err_i,
    output logic [NUM_CH-1:0]          ch_busy_o,
    output logic [NUM_CH-1:0]          ch_done_o,
    output logic [NUM_CH-1:0]          ch_err_o,
    output logic                       busy_o,
    output logic                       err_o
);

    localparam int unsigned IW = CARBONDMA_SCHED_CH_IDX_W;

    sched_state_e   state_q, state_n;
    logic [NUM_CH-1:0] pending_q, pending_n, active_q, active_n;
    logic [NUM_CH-1:0] done_q, done_n, err_q, err_n, cbusy_q, cbusy_n;
    logic           gerr_q, gerr_n, valid_q, valid_n, busy_q, busy_n;
    logic [IW-1:0]  ptr_q, ptr_n, ch_q, ch_n;
    carbondma_job_t job_q, job_n;

    logic [NUM_CH-1:0] arb_req, gnt;
    logic [IW-1:0]     gidx;
    logic              gany;

`ifdef CARBONDMA_SCHED_PRIO_EN
    // High-priority pending channels shadow the low class entirely.
    logic [NUM_CH-1:0] hi_req;
    assign hi_req  = pending_q & ch_prio_i;
    assign arb_req = (|hi_req) ? hi_req : pending_q;
`else
    logic [NUM_CH-1:0] prio_unused;
    assign prio_unused = ch_prio_i;
    assign arb_req     = pending_q;
`endif

    carbondma_rr_arb #(.N(NUM_CH), .IDX_W(IW)) u_arb (
        .req (arb_req),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gidx),
        .any (gany)
    );

    function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] c);
        return (32'(c) == NUM_CH - 1) ? '0 : c + IW'(1);
    endfunction

    // Configuration of the granted channel, sampled at grant time.
    logic                sel_op;
    logic [ADDR_W-1:0]   sel_src, sel_dst;
    logic [LEN_W-1:0]    sel_len;
    logic [31:0]         sel_fill;

    always_comb begin
        sel_op   = |(ch_fill_i & gnt);
        sel_src  = '0;
        sel_dst  = '0;
        sel_len  = '0;
        sel_fill = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (gnt[c]) begin
                sel_src  = ch_src_i[c*ADDR_W +: ADDR_W];
                sel_dst  = ch_dst_i[c*ADDR_W +: ADDR_W];
                sel_len  = ch_len_i[c*LEN_W +: LEN_W];
                sel_fill = ch_fillval_i[c*32 +: 32];
            end
        end
    end

    // Ordering: clear-error, engine completion, starts, then grant/handshake.
    always_comb begin
        state_n   = state_q;
        pending_n = pending_q;
        active_n  = active_q;
        done_n    = done_q;
        err_n     = err_q;
        gerr_n    = gerr_q;
        valid_n   = valid_q;
        ptr_n     = ptr_q;
        ch_n      = ch_q;
        job_n     = job_q;

        if (clr_err_i) begin
            err_n  = '0;
            gerr_n = 1'b0;
        end

        if (state_q == SCHED_WAIT && eng_done_i) begin
            done_n = done_n | active_q;
            if (eng_err_i) begin
                err_n  = err_n | active_q;
                gerr_n = 1'b1;
            end
            active_n = '0;
            ptr_n    = ptr_after(ch_q);
            state_n  = SCHED_IDLE;
        end

        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_start_i[c]) begin
                if (pending_q[c] || active_n[c]) begin
                    err_n[c] = 1'b1;
                    gerr_n   = 1'b1;
                end else begin
                    pending_n[c] = 1'b1;
                    done_n[c]    = 1'b0;
                    err_n[c]     = 1'b0;
                end
            end
        end

        case (state_q)
            SCHED_IDLE: begin
                if (en_i && gany) begin
                    pending_n  = pending_n & ~gnt;
                    ch_n       = gidx;
                    job_n.op   = sel_op;
                    job_n.src  = CARBONDMA_JOB_ADDR_W'(sel_src);
                    job_n.dst  = CARBONDMA_JOB_ADDR_W'(sel_dst);
                    job_n.len  = CARBONDMA_JOB_LEN_W'(sel_len);
                    job_n.fill = sel_fill;
                    if (sel_len == '0) begin
                        done_n = done_n | gnt;
                        ptr_n  = ptr_after(gidx);
                    end else begin
                        active_n = gnt;
                        valid_n  = 1'b1;
                        state_n  = SCHED_ISSUE;
                    end
                end
            end
            SCHED_ISSUE: begin
                if (eng_req_ready_i) begin
                    valid_n = 1'b0;
                    state_n = SCHED_WAIT;
                end
            end
            default: ;
        endcase

        cbusy_n = pending_n | active_n;
        busy_n  = |cbusy_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= SCHED_IDLE;
            pending_q <= '0;
            active_q  <= '0;
            done_q    <= '0;
            err_q     <= '0;
            cbusy_q   <= '0;
            gerr_q    <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            ptr_q     <= '0;
            ch_q      <= '0;
            job_q     <= '0;
        end else begin
            state_q   <= state_n;
            pending_q <= pending_n;
            active_q  <= active_n;
            done_q    <= done_n;
            err_q     <= err_n;
            cbusy_q   <= cbusy_n;
            gerr_q    <= gerr_n;
            valid_q   <= valid_n;
            busy_q    <= busy_n;
            ptr_q     <= ptr_n;
            ch_q      <= ch_n;
            job_q     <= job_n;
        end
    end

    assign eng_req_valid_o = valid_q;
    assign eng_req_ch_o    = ch_q;
    assign eng_req_op_o    = job_q.op;
    assign eng_req_src_o   = ADDR_W'(job_q.src);
    assign eng_req_dst_o   = ADDR_W'(job_q.dst);
    assign eng_req_len_o   = LEN_W'(job_q.len);
    assign eng_req_fill_o  = job_q.fill;
    assign ch_busy_o       = cbusy_q;
    assign ch_done_o       = done_q;
    assign ch_err_o        = err_q;
    assign busy_o          = busy_q;
    assign err_o           = gerr_q;

endmodule

// File: tb/tb_carbondma_ch_sched.sv
// Directed self-checking bench for carbondma_ch_sched (4 channels, 64-bit addresses).
module tb_carbondma_ch_sched;
    import carbondma_pkg::*;

    localparam int unsigned NCH = 4;

    logic clk = 1'b0;
    logic rst_n, en, clr_err, ready, done, eerr;
    logic [NCH-1:0]    start, fill, prio;
    logic [NCH*64-1:0] src, dst;
    logic [NCH*32-1:0] len, fillval;
    logic              valid, op, busy, gerr;
    logic [2:0]        rch;
    logic [63:0]       rsrc, rdst;
    logic [31:0]       rlen, rfill;
    logic [NCH-1:0]    cbusy, cdone, cerr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    carbondma_ch_sched #(.NUM_CH(NCH), .ADDR_W(64), .LEN_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en), .clr_err_i(clr_err),
        .ch_start_i(start), .ch_fill_i(fill), .ch_src_i(src), .ch_dst_i(dst),
        .ch_len_i(len), .ch_fillval_i(fillval), .ch_prio_i(prio),
        .eng_req_valid_o(valid), .eng_req_ready_i(ready), .eng_req_ch_o(rch),
        .eng_req_op_o(op), .eng_req_src_o(rsrc), .eng_req_dst_o(rdst),
        .eng_req_len_o(rlen), .eng_req_fill_o(rfill),
        .eng_done_i(done), .eng_err_i(eerr),
        .ch_busy_o(cbusy), .ch_done_o(cdone), .ch_err_o(cerr),
        .busy_o(busy), .err_o(gerr)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int c, input logic [63:0] s, input logic [63:0] d,
                          input logic [31:0] l, input logic o, input logic [31:0] fv);
        src[c*64 +: 64]     = s;
        dst[c*64 +: 64]     = d;
        len[c*32 +: 32]     = l;
        fill[c]             = o;
        fillval[c*32 +: 32] = fv;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Wait (bounded) for a request, check its channel, then ready and done in turn.
    task automatic serve(input string tag, input logic [2:0] exp_ch);
        int n = 0;
        while (!valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 64'(valid), 64'(1));
        chk({tag, "_ch"}, 64'(rch), 64'(exp_ch));
        ready = 1'b1;
        step();
        ready = 1'b0;
        done  = 1'b1;
        step();
        done  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; clr_err = 1'b0; ready = 1'b0; done = 1'b0; eerr = 1'b0;
        start = '0; fill = '0; prio = '0; src = '0; dst = '0; len = '0; fillval = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst_valid", 64'(valid), 64'(0));
        chk("rst_busy", 64'({busy, cbusy}), 64'(0));
        chk("rst_err", 64'({gerr, cerr}), 64'(0));
        chk("rst_done", 64'(cdone), 64'(0));

        // Single copy on ch1
        en = 1'b1;
        set_ch(1, 64'h1000, 64'h2000, 32'd64, CARBONDMA_OP_COPY, 32'h0);
        start = 4'b0010;
        step();
        start = '0;
        chk("cp_busy", 64'(cbusy), 64'(4'b0010));
        chk("cp_novalid", 64'(valid), 64'(0));
        step();
        chk("cp_valid", 64'(valid), 64'(1));
        chk("cp_ch", 64'(rch), 64'(1));
        chk("cp_op", 64'(op), 64'(CARBONDMA_OP_COPY));
        chk("cp_src", rsrc, 64'h1000);
        chk("cp_dst", rdst, 64'h2000);
        chk("cp_len", 64'(rlen), 64'd64);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("cp_drop", 64'(valid), 64'(0));
        chk("cp_wait_busy", 64'(busy), 64'(1));
        done = 1'b1;
        step();
        done = 1'b0;
        chk("cp_done", 64'(cdone), 64'(4'b0010));
        chk("cp_idle", 64'({busy, cbusy}), 64'(0));

        // Fairness from pointer 0, then wrap back to 0
        do_reset();
        for (int c = 0; c < 4; c++)
            set_ch(c, 64'(32'h100 * (c + 1)), 64'(32'h8000 + c), 32'd32, CARBONDMA_OP_COPY, 32'h0);
        start = 4'hF;
        step();
        start = '0;
        chk("rr_busy", 64'(cbusy), 64'(4'hF));
        serve("rr_a0", 3'd0);
        serve("rr_a1", 3'd1);
        serve("rr_a2", 3'd2);
        serve("rr_a3", 3'd3);
        chk("rr_done", 64'(cdone), 64'(4'hF));
        chk("rr_idle", 64'(busy), 64'(0));
        start = 4'hF;
        step();
        start = '0;
        serve("rr_b0", 3'd0);
        serve("rr_b1", 3'd1);
        serve("rr_b2", 3'd2);
        serve("rr_b3", 3'd3);

        // Backpressure on a fill job, then completion with error
        set_ch(2, 64'h3000, 64'h4000, 32'd16, CARBONDMA_OP_FILL, 32'hA5A5_A5A5);
        start = 4'b0100;
        step();
        start = '0;
        step();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 64'(valid), 64'(1));
            chk("bp_ch", 64'(rch), 64'(2));
            chk("bp_fill", 64'(rfill), 64'(32'hA5A5_A5A5));
            chk("bp_src", rsrc, 64'h3000);
            step();
        end
        chk("bp_op", 64'(op), 64'(CARBONDMA_OP_FILL));
        ready = 1'b1;
        step();
        ready = 1'b0;
        done = 1'b1;
        eerr = 1'b1;
        step();
        done = 1'b0;
        eerr = 1'b0;
        chk("bp_cerr", 64'(cerr), 64'(4'b0100));
        chk("bp_gerr", 64'(gerr), 64'(1));
        chk("bp_done2", 64'(cdone[2]), 64'(1));
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("clr_cerr", 64'(cerr), 64'(0));
        chk("clr_gerr", 64'(gerr), 64'(0));

        // Zero length on ch2 completes without an engine request
        set_ch(2, 64'h3000, 64'h4000, 32'd0, CARBONDMA_OP_COPY, 32'h0);
        start = 4'b0100;
        step();
        start = '0;
        chk("zl_busy", 64'(cbusy), 64'(4'b0100));
        chk("zl_done_clr", 64'(cdone[2]), 64'(0));
        chk("zl_novalid0", 64'(valid), 64'(0));
        step();
        chk("zl_done", 64'(cdone[2]), 64'(1));
        chk("zl_idle", 64'(cbusy), 64'(0));
        chk("zl_novalid1", 64'(valid), 64'(0));

        // Second start on busy ch3: error flagged, single job
        set_ch(3, 64'h5000, 64'h6000, 32'd8, CARBONDMA_OP_COPY, 32'h0);
        start = 4'b1000;
        step();
        step();
        start = '0;
        chk("dbl_cerr", 64'(cerr), 64'(4'b1000));
        chk("dbl_gerr", 64'(gerr), 64'(1));
        serve("dbl", 3'd3);
        for (int i = 0; i < 3; i++) begin
            chk("dbl_once", 64'(valid), 64'(0));
            step();
        end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;

        // Disable: active ch0 finishes, pending ch1 waits for enable
        set_ch(0, 64'h10, 64'h20, 32'd4, CARBONDMA_OP_COPY, 32'h0);
        set_ch(1, 64'h30, 64'h40, 32'd4, CARBONDMA_OP_COPY, 32'h0);
        start = 4'b0001;
        step();
        start = '0;
        step();
        chk("dis_v0", 64'(valid), 64'(1));
        en = 1'b0;
        start = 4'b0010;
        ready = 1'b1;
        step();
        start = '0;
        ready = 1'b0;
        done = 1'b1;
        step();
        done = 1'b0;
        chk("dis_done0", 64'(cdone[0]), 64'(1));
        chk("dis_pend1", 64'(cbusy), 64'(4'b0010));
        for (int i = 0; i < 3; i++) begin
            chk("dis_hold", 64'(valid), 64'(0));
            step();
        end
        en = 1'b1;
        serve("dis_en", 3'd1);
        chk("dis_done01", 64'(cdone[1:0]), 64'(2'b11));

        // Start and completion of ch0 in the same cycle
        start = 4'b0001;
        step();
        start = '0;
        step();
        chk("sc_v", 64'(valid), 64'(1));
        ready = 1'b1;
        step();
        ready = 1'b0;
        done = 1'b1;
        start = 4'b0001;
        step();
        done = 1'b0;
        start = '0;
        chk("sc_done", 64'(cdone[0]), 64'(0));
        chk("sc_busy", 64'(cbusy[0]), 64'(1));
        chk("sc_err", 64'(cerr[0]), 64'(0));
        serve("sc", 3'd0);

        // Reset while waiting, then a stray completion
        start = 4'b0010;
        step();
        start = '0;
        step();
        ready = 1'b1;
        step();
        ready = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        done = 1'b1;
        step();
        done = 1'b0;
        chk("wr_done", 64'(cdone), 64'(0));
        chk("wr_busy", 64'({busy, cbusy}), 64'(0));
        chk("wr_err", 64'({gerr, cerr}), 64'(0));
        chk("wr_valid", 64'(valid), 64'(0));

        // Arbitration among ch0..ch2 with ch2 high priority
        prio = 4'b0100;
        set_ch(2, 64'h70, 64'h80, 32'd4, CARBONDMA_OP_COPY, 32'h0);
        start = 4'b0111;
        step();
        start = '0;
`ifdef CARBONDMA_SCHED_PRIO_EN
        serve("pr_0", 3'd2);
        serve("pr_1", 3'd0);
        serve("pr_2", 3'd1);
`else
        serve("pr_0", 3'd0);
        serve("pr_1", 3'd1);
        serve("pr_2", 3'd2);
`endif
        chk("pr_done", 64'(cdone), 64'(4'b0111));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/carbondma_ch_sched.md
Name: carbondma_ch_sched

Overview:
- Per-channel job scheduler for the CarbonDMA compatibility path.
- Latches start requests from the channel register file and arbitrates round-robin among pending channels.
- Issues one copy/fill job at a time to the single shared CarbonDMA transfer engine.
- Tracks per-channel busy/done/err status and the global busy/err flags reported by the compat STATUS register.

Parameters:
- NUM_CH, 4: number of channels; range 1..8.
- ADDR_W, 64: source/destination address width (SRC_HI:SRC_LO).
- LEN_W, 32: transfer length width, in bytes.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous, active-low reset
- en_i  in  1  global CTRL.ENABLE
- clr_err_i  in  1  CTRL.CLR_ERR pulse; clears global and all channel err bits
- ch_start_i  in  NUM_CH  CH_CTRL.START write pulse, one bit per channel
- ch_fill_i  in  NUM_CH  CH_CTRL.FILL: 1=fill, 0=copy
- ch_src_i  in  NUM_CH*ADDR_W  channel source addresses, packed
- ch_dst_i  in  NUM_CH*ADDR_W  channel destination addresses
- ch_len_i  in  NUM_CH*LEN_W  channel lengths
- ch_fillval_i  in  NUM_CH*32  channel fill patterns
- ch_prio_i  in  NUM_CH  high-priority flag; used only with the optional feature
- eng_req_valid_o  out  1  job valid to engine
- eng_req_ready_i  in  1  engine accepts job
- eng_req_ch_o  out  3  granted channel index
- eng_req_op_o  out  1  CARBONDMA_OP_COPY / CARBONDMA_OP_FILL
- eng_req_src_o  out  ADDR_W  job source address
- eng_req_dst_o  out  ADDR_W  job destination address
- eng_req_len_o  out  LEN_W  job length
- eng_req_fill_o  out  32  job fill pattern
- eng_done_i  in  1  engine completion pulse
- eng_err_i  in  1  qualifies eng_done_i: job faulted
- ch_busy_o  out  NUM_CH  pending or active per channel
- ch_done_o  out  NUM_CH  sticky done
- ch_err_o  out  NUM_CH  sticky error
- busy_o  out  1  OR of ch_busy_o
- err_o  out  1  sticky global error

Behaviour:
- Reset: all outputs 0; pending, done and err bits cleared; FSM = IDLE; round-robin pointer = 0. Reset mid-job abandons the job; a late eng_done_i after reset is ignored because the FSM is not in WAIT.
- Start on an idle channel: sets pending[c], clears done[c] and err[c]. ch_busy_o[c]=1 on the next cycle.
- Start on a busy channel: ignored; sets err[c] and err_o.
- Configuration is sampled at grant, not at start.
- FSM IDLE: if en_i and any pending bit is set, pick the winner from the round-robin starting at ptr. Capture the job into output registers, clear pending[c], mark active, go to ISSUE. Grant to eng_req_valid_o is 1 cycle after pending is visible.
- Zero length: if ch_len[c]==0 at grant, the channel completes in IDLE. Next cycle done[c]=1, busy cleared, no engine request.
- FSM ISSUE: eng_req_valid_o=1 with payload held stable until eng_req_ready_i. On handshake go to WAIT. Valid is never dropped without ready.
- FSM WAIT: on eng_done_i, set done[c]; if eng_err_i also set err[c] and err_o. Clear active, set ptr = c+1 mod NUM_CH, go to IDLE. The next grant is possible the following cycle.
- Disable: en_i=0 blocks new grants only. ISSUE and WAIT run to completion. Pending bits are retained.
- Same-cycle start[c] and done of channel c: done wins first, so the channel is idle, then the start is accepted. Result: pending[c]=1, done[c]=0.
- Same-cycle clr_err_i and a new error: the new error wins (err stays 1).
- Round-robin pointer wraps NUM_CH-1 -> 0.

Optional Feature:
- CARBONDMA_SCHED_PRIO_EN defined: pending channels with ch_prio_i=1 form a high class that always wins over the low class. Round-robin applies within each class using the shared pointer. A low-priority channel may starve.
- Not defined: ch_prio_i is ignored and arbitration is pure round-robin.

Decomposition:
- Add to carbondma_pkg: sched FSM enum (IDLE/ISSUE/WAIT), CARBONDMA_SCHED_CH_IDX_W=3, and a job struct (op, src, dst, len, fill).
- Reuse the existing CARBONDMA_OP_* and channel status bit constants.
- One sub-module: carbondma_rr_arb, a parameterised round-robin grant given request vector and pointer, returning one-hot grant and index.

Test Plan:
- Single copy: ch1 src=0x1000, dst=0x2000, len=64, start -> one engine request ch=1, op=COPY, payload exact; done pulse -> ch_done_o=0b0010, busy_o=0.
- Fairness: start ch0..ch3 together, engine ready/done at 1-cycle latency -> grant order 0,1,2,3. Restart all -> order continues from the pointer: 0,1,2,3.
- Backpressure plus error: hold eng_req_ready_i low 10 cycles -> valid held, payload stable. Then done with err -> ch_err_o[c]=1, err_o=1. clr_err_i -> both 0.
- Edge cases: len=0 on ch2 -> done with no eng_req_valid_o. Start ch3 twice while busy -> ch_err_o[3]=1, only one job issued.
- Disable: en_i=0 with ch0 active and ch1 pending -> ch0 completes, ch1 not granted. en_i=1 -> ch1 issued.
- Reset: assert rst_n=0 in WAIT, then send a stray eng_done_i -> all status 0, no done set.
- Optional, with CARBONDMA_SCHED_PRIO_EN: ch2 with prio=1 and ch0/ch1 pending -> ch2 granted first.
